pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use stalls, taken-branch flushes and multicycle EX operations, where EX is frozen until the unit reports done. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a five-stage RISC-V pipeline: load-use
// stalls, taken-branch flushes, multicycle EX freeze and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_op,
  input  logic                  mc_done,
  output logic                  mc_start,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu_hazard;

  // Load-use detection; x0 is hardwired to zero so it never creates a dependency.
  always_comb begin
    lu_hazard = 1'b0;
    if (ex_is_load && (ex_rd != {REG_ADDR_W{1'b0}})) begin
      lu_hazard = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd));
    end else begin
      lu_hazard = 1'b0;
    end
  end

  // Next-state and control outputs; while in reset the pipeline is held flushed.
  always_comb begin
    state_d     = state_q;
    mc_start    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      state_d     = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mc_op) begin
            mc_start    = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = MC_BUSY;
          end else if (lu_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            state_d = RUN;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl, checked against a
// cycle-level reference model (busy flag plus a clamped integer stall count).
module tb_pipe_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, ex_mc_op, mc_done;
  logic          mc_start, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_busy = 1'b0;
  int m_cnt  = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .mc_start(mc_start), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rn, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit ld, input bit br, input bit mc, input bit dn);
    rst_n = rn; id_rs1 = AW'(rs1); id_uses_rs1 = u1; id_rs2 = AW'(rs2); id_uses_rs2 = u2;
    ex_rd = AW'(rd); ex_is_load = ld; ex_branch_taken = br; ex_mc_op = mc; mc_done = dn;
  endtask

  task automatic idle(input bit dn);
    drive(1'b1, 1, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0, 1'b0, dn);
  endtask

  // One cycle: compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cyc(input bit do_chk);
    bit lu, e_start, e_pc, e_ifid, e_idex, e_ifl, e_idfl, e_exfl;
    #1;
    if (!rst_n) begin m_busy = 1'b0; m_cnt = 0; end
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {e_start, e_pc, e_ifid, e_idex, e_ifl, e_idfl, e_exfl} = 7'b0111000;
    if (!rst_n)               {e_start, e_pc, e_ifid, e_idex, e_ifl, e_idfl, e_exfl} = 7'b0000111;
    else if (m_busy)          {e_pc, e_ifid, e_idex, e_exfl} = mc_done ? 4'b1110 : 4'b0001;
    else if (ex_branch_taken) {e_ifl, e_idfl} = 2'b11;
    else if (ex_mc_op)        {e_start, e_pc, e_ifid, e_idex, e_exfl} = 5'b10001;
    else if (lu)              {e_pc, e_ifid, e_idfl} = 3'b001;
    if (do_chk) begin
      chk("mc_start", mc_start, e_start);
      chk("pc_en", pc_en, e_pc);
      chk("ifid_en", ifid_en, e_ifid);
      chk("idex_en", idex_en, e_idex);
      chk("ifid_flush", ifid_flush, e_ifl);
      chk("idex_flush", idex_flush, e_idfl);
      chk("exmem_flush", exmem_flush, e_exfl);
      chk("stall_cnt", int'(stall_cnt), m_cnt);
    end
    @(posedge clk);
    if (rst_n) begin
      if (!e_pc && m_cnt < CMAX) m_cnt++;
      if (m_busy && mc_done) m_busy = 1'b0;
      else if (!m_busy && !ex_branch_taken && ex_mc_op) m_busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1));
    cyc(1'b1);
    idle(1'b0);
    cyc(1'b0);
  endtask

  initial begin
    idle(1'b0);
    rst_n = 1'b0;
    @(negedge clk);

    // reset held 3 cycles with random inputs, then released with no hazards
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1));
      cyc(1'b1);
    end
    idle(1'b0); cyc(1'b0);
    idle(1'b0); cyc(1'b1);
    chk("idle_pc_en", pc_en, 1);

    // load-use on rs2: exactly one stall
    drive(1'b1, 7, 1'b1, 5, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1);
    idle(1'b0); cyc(1'b1);
    chk("lu_cnt", int'(stall_cnt), 1);
    // same pattern through x0: no stall
    drive(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1);
    // load-use on rs1, then without the use flag
    drive(1'b1, 9, 1'b1, 2, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1);
    drive(1'b1, 9, 1'b0, 2, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1);
    // branch overrides load-use and multicycle
    drive(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b0); cyc(1'b1);
    idle(1'b0); cyc(1'b1);
    chk("br_cnt", int'(stall_cnt), 2);

    // multicycle op with mc_done 4 cycles after mc_start, then back-to-back launch
    drive(1'b1, 1, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0); cyc(1'b1);
    for (int i = 0; i < 3; i++) begin idle(1'b0); cyc(1'b1); end
    idle(1'b1); cyc(1'b1);
    chk("mc_cnt", int'(stall_cnt), 6);
    drive(1'b1, 1, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0); cyc(1'b1);
    idle(1'b1); cyc(1'b1);
    // mc_done while running is ignored
    idle(1'b1); cyc(1'b1);
    idle(1'b0); cyc(1'b1);

    // reset two cycles into MC_BUSY, then a stray mc_done
    do_reset();
    drive(1'b1, 1, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0); cyc(1'b1);
    idle(1'b0); cyc(1'b1);
    idle(1'b0); rst_n = 1'b0; cyc(1'b1);
    idle(1'b0); cyc(1'b0);
    idle(1'b1); cyc(1'b1);
    chk("rst_mid_cnt", int'(stall_cnt), 0);
    idle(1'b0); cyc(1'b1);

    // saturation with 20 consecutive load-use cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1);
    end
    idle(1'b0); cyc(1'b1);
    chk("sat_cnt", int'(stall_cnt), 15);

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0));
      if (!m_busy && ex_mc_op) mc_done = 1'b0;
      cyc(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
